// File: rtl/wb_result_unit.sv
// wb_result_unit: registered write-back source select with load wait/extend and valid/ready output
module wb_result_unit #(
    parameter int XLEN = 32,
    parameter int NSRC = 4,
    parameter int SELW = $clog2(NSRC)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SELW-1:0]      in_src_sel,
    input  logic [NSRC*XLEN-1:0] in_srcs,
    input  logic [2:0]           in_funct3,
    input  logic [1:0]           in_byte_off,
    input  logic [4:0]           in_rd,
    input  logic                 in_reg_write,
    input  logic                 mem_rvalid,
    input  logic [XLEN-1:0]      mem_rdata,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic                 wb_we,
    output logic [4:0]           wb_rd,
    output logic [XLEN-1:0]      wb_data
);
    typedef enum logic [1:0] {IDLE, WAIT_MEM, OUT} state_t;
    state_t state;
    logic [2:0] funct3;
    logic [1:0] byte_off;
    logic accept, is_load;
    logic [XLEN-1:0] src_val, shifted, load_val;

    assign in_ready = state == IDLE || (state == OUT && wb_ready);
    assign accept = in_valid && in_ready;
    assign is_load = in_src_sel == SELW'(1);
    assign shifted = mem_rdata >> {byte_off, 3'b000};

    always_comb begin
        src_val = '0;
        for (int k = 0; k < NSRC; k++)
            if (int'(in_src_sel) == k) src_val = in_srcs[k*XLEN +: XLEN];
    end

    // sized casts of signed slices sign-extend; unsigned slices zero-extend
    always_comb
        load_val = funct3 == 3'b000 ? XLEN'($signed(shifted[7:0])) :
                   funct3 == 3'b001 ? XLEN'($signed(shifted[15:0])) :
                   funct3 == 3'b010 ? XLEN'($signed(shifted[31:0])) :
                   funct3 == 3'b100 ? XLEN'(shifted[7:0]) :
                   funct3 == 3'b101 ? XLEN'(shifted[15:0]) :
                   funct3 == 3'b110 ? XLEN'(shifted[31:0]) : mem_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            funct3   <= '0;
            byte_off <= '0;
        end else if (accept) begin
            wb_rd <= in_rd;
            wb_we <= in_reg_write && in_rd != 5'd0;
            if (is_load) begin
                funct3   <= in_funct3;
                byte_off <= in_byte_off;
                state    <= WAIT_MEM;
                wb_valid <= 1'b0;
            end else begin
                wb_data  <= src_val;
                state    <= OUT;
                wb_valid <= 1'b1;
            end
        end else if (state == WAIT_MEM && mem_rvalid) begin
            wb_data  <= load_val;
            state    <= OUT;
            wb_valid <= 1'b1;
        end else if (state == OUT && wb_ready) begin
            state    <= IDLE;
            wb_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_wb_result_unit.sv
// tb_wb_result_unit: table vectors, directed corner sequences and a randomized model check
module tb_wb_result_unit;
    localparam int XL = 32, NS = 5, SW = 3;

    logic clk = 1'b0, reset;
    logic in_valid, in_ready, in_reg_write, mem_rvalid, wb_valid, wb_ready, wb_we;
    logic [SW-1:0] in_src_sel;
    logic [NS*XL-1:0] in_srcs;
    logic [2:0] in_funct3;
    logic [1:0] in_byte_off;
    logic [4:0] in_rd, wb_rd;
    logic [XL-1:0] mem_rdata, wb_data;

    logic h_valid, h_ready, h_we_in, h_rvalid, h_wbv, h_wbr, h_we;
    logic [1:0] h_sel, h_off;
    logic [191:0] h_srcs;
    logic [2:0] h_f3;
    logic [4:0] h_rd, h_wbrd;
    logic [63:0] h_rdata, h_data;

    wb_result_unit #(.XLEN(XL), .NSRC(NS)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_src_sel(in_src_sel), .in_srcs(in_srcs), .in_funct3(in_funct3),
        .in_byte_off(in_byte_off), .in_rd(in_rd), .in_reg_write(in_reg_write),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
        .wb_ready(wb_ready), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data));

    wb_result_unit #(.XLEN(64), .NSRC(3)) dut64 (
        .clk(clk), .reset(reset), .in_valid(h_valid), .in_ready(h_ready),
        .in_src_sel(h_sel), .in_srcs(h_srcs), .in_funct3(h_f3),
        .in_byte_off(h_off), .in_rd(h_rd), .in_reg_write(h_we_in),
        .mem_rvalid(h_rvalid), .mem_rdata(h_rdata), .wb_valid(h_wbv),
        .wb_ready(h_wbr), .wb_we(h_we), .wb_rd(h_wbrd), .wb_data(h_data));

    always #5 clk = ~clk;

    int errs = 0, checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] sext(input logic [63:0] v, input int n);
        logic [63:0] m = 64'd1 << (n - 1);
        logic [63:0] t = v & ((m << 1) - 64'd1);
        return (t ^ m) - m;
    endfunction

    function automatic logic [63:0] ref_ext(input logic [63:0] raw, input logic [2:0] f3,
                                            input logic [1:0] off, input int xlen);
        logic [63:0] mask = xlen == 64 ? '1 : 64'hFFFF_FFFF;
        logic [63:0] s = (raw & mask) >> (8 * off);
        logic [63:0] r;
        case (f3)
            3'd0: r = sext(s, 8);
            3'd1: r = sext(s, 16);
            3'd2: r = sext(s, 32);
            3'd4: r = s & 64'hFF;
            3'd5: r = s & 64'hFFFF;
            3'd6: r = s & 64'hFFFF_FFFF;
            default: r = raw;
        endcase
        return r & mask;
    endfunction

    typedef struct {
        logic [2:0] sel; logic [2:0] f3; logic [1:0] off;
        logic [31:0] src; logic [31:0] rdata; logic [31:0] exp;
        logic [4:0] rd; logic we; logic exp_we;
    } vec_t;
    vec_t tv[15];

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        in_srcs = {$urandom, $urandom, $urandom, $urandom, $urandom};
        if (v.sel < NS && v.sel != 1) in_srcs[v.sel*XL +: XL] = v.src;
        in_valid = 1; in_src_sel = v.sel; in_funct3 = v.f3; in_byte_off = v.off;
        in_rd = v.rd; in_reg_write = v.we; wb_ready = 1; mem_rvalid = 0;
        #1 chk($sformatf("vec%0d_in_ready", idx), in_ready, 1);
        @(negedge clk);
        in_valid = 0; in_funct3 = 3'($urandom); in_byte_off = 2'($urandom);
        if (v.sel == 1) begin
            for (int i = 0; i < 3; i++) begin
                #1 chk($sformatf("vec%0d_wait_valid", idx), wb_valid, 0);
                chk($sformatf("vec%0d_wait_ready", idx), in_ready, 0);
                @(negedge clk);
            end
            mem_rvalid = 1; mem_rdata = v.rdata;
            @(negedge clk);
            mem_rvalid = 0;
        end
        #1 chk($sformatf("vec%0d_valid", idx), wb_valid, 1);
        chk($sformatf("vec%0d_data", idx), wb_data, v.exp);
        chk($sformatf("vec%0d_we", idx), wb_we, v.exp_we);
        chk($sformatf("vec%0d_rd", idx), wb_rd, v.rd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] vals[4];
        int sels[4] = '{0, 2, 3, 0};
        logic [63:0] h_exp, h_slot2;
        bit out_full, load_wait, exp_ready, cur_we, pend_we;
        logic [4:0] cur_rd, pend_rd;
        logic [31:0] cur_data;
        logic [2:0] pend_f3;
        logic [1:0] pend_off;

        tv[0]  = '{3'd0, 3'd0, 2'd0, 32'h0000_1234, 32'h0,          32'h0000_1234, 5'd5,  1'b1, 1'b1};
        tv[1]  = '{3'd1, 3'd0, 2'd2, 32'h0,         32'h0080_0000, 32'hFFFF_FF80, 5'd7,  1'b1, 1'b1};
        tv[2]  = '{3'd1, 3'd4, 2'd2, 32'h0,         32'h0080_0000, 32'h0000_0080, 5'd8,  1'b1, 1'b1};
        tv[3]  = '{3'd1, 3'd5, 2'd2, 32'h0,         32'h8001_0000, 32'h0000_8001, 5'd9,  1'b1, 1'b1};
        tv[4]  = '{3'd1, 3'd1, 2'd0, 32'h0,         32'h0000_8123, 32'hFFFF_8123, 5'd10, 1'b1, 1'b1};
        tv[5]  = '{3'd1, 3'd2, 2'd1, 32'h0,         32'h8000_0012, 32'h0080_0000, 5'd11, 1'b1, 1'b1};
        tv[6]  = '{3'd1, 3'd7, 2'd3, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd12, 1'b1, 1'b1};
        tv[7]  = '{3'd1, 3'd0, 2'd3, 32'h0,         32'h8000_0000, 32'hFFFF_FF80, 5'd13, 1'b1, 1'b1};
        tv[8]  = '{3'd1, 3'd6, 2'd1, 32'h0,         32'h1234_5678, 32'h0012_3456, 5'd14, 1'b0, 1'b0};
        tv[9]  = '{3'd2, 3'd0, 2'd0, 32'hAAAA_0004, 32'h0,         32'hAAAA_0004, 5'd1,  1'b1, 1'b1};
        tv[10] = '{3'd4, 3'd0, 2'd0, 32'h0BAD_F00D, 32'h0,         32'h0BAD_F00D, 5'd31, 1'b1, 1'b1};
        tv[11] = '{3'd7, 3'd0, 2'd0, 32'h0,         32'h0,         32'h0,         5'd3,  1'b1, 1'b1};
        tv[12] = '{3'd3, 3'd0, 2'd0, 32'h0000_0055, 32'h0,         32'h0000_0055, 5'd0,  1'b1, 1'b0};
        tv[13] = '{3'd5, 3'd0, 2'd0, 32'h0,         32'h0,         32'h0,         5'd2,  1'b0, 1'b0};
        tv[14] = '{3'd1, 3'd3, 2'd0, 32'h0,         32'hCAFE_F00D, 32'hCAFE_F00D, 5'd6,  1'b1, 1'b1};

        reset = 1; in_valid = 0; in_src_sel = 0; in_srcs = '0; in_funct3 = 0; in_byte_off = 0;
        in_rd = 0; in_reg_write = 0; mem_rvalid = 0; mem_rdata = 0; wb_ready = 1;
        h_valid = 0; h_sel = 0; h_srcs = '0; h_f3 = 0; h_off = 0; h_rd = 0; h_we_in = 0;
        h_rvalid = 0; h_rdata = 0; h_wbr = 1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_we", wb_we, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst64_in_ready", h_ready, 1);
        chk("rst64_wb_data", h_data, 0);
        repeat (2) @(negedge clk);
        reset = 0;
        #1 chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_wb_valid", wb_valid, 0);

        // 64-bit instance: loads through the reference extender, then slot 2 and out-of-range slot 3
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            h_srcs = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            h_slot2 = h_srcs[128 +: 64];
            h_valid = 1; h_sel = i < 9 ? 2'd1 : 2'(i - 7);
            h_f3 = i == 0 ? 3'd2 : 3'($urandom); h_off = i == 0 ? 2'd0 : 2'($urandom);
            h_rd = 5'(i + 1); h_we_in = 1;
            h_rdata = i == 0 ? 64'h0000_0000_8000_0000 : {$urandom, $urandom};
            h_exp = h_sel == 2'd1 ? ref_ext(h_rdata, h_f3, h_off, 64) : h_sel == 2'd2 ? h_slot2 : 64'd0;
            if (i == 0) chk("p64_model", h_exp, 64'hFFFF_FFFF_8000_0000);
            @(negedge clk);
            h_valid = 0;
            if (h_sel == 2'd1) begin
                h_rvalid = 1;
                @(negedge clk);
                h_rvalid = 0;
            end
            #1 chk($sformatf("p64_%0d_valid", i), h_wbv, 1);
            chk($sformatf("p64_%0d_data", i), h_data, h_exp);
            chk($sformatf("p64_%0d_rd", i), h_wbrd, 64'(i + 1));
        end
        @(negedge clk);

        for (int i = 0; i < 15; i++) run_vec(tv[i], i);

        // back-to-back streaming with wb_ready held high
        wb_ready = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("stream%0d_valid", i - 1), wb_valid, 1);
                chk($sformatf("stream%0d_data", i - 1), wb_data, vals[i-1]);
                chk($sformatf("stream%0d_rd", i - 1), wb_rd, 64'(20 + i - 1));
            end
            vals[i] = $urandom;
            in_srcs = {$urandom, $urandom, $urandom, $urandom, $urandom};
            in_srcs[sels[i]*XL +: XL] = vals[i];
            in_valid = 1; in_src_sel = 3'(sels[i]); in_rd = 5'(20 + i); in_reg_write = 1;
            #1 chk($sformatf("stream%0d_in_ready", i), in_ready, 1);
        end
        @(negedge clk);
        in_valid = 0;
        chk("stream3_valid", wb_valid, 1);
        chk("stream3_data", wb_data, vals[3]);
        @(negedge clk);
        chk("stream_drain", wb_valid, 0);

        // backpressure: result must hold while a competing offer waits
        in_valid = 1; in_src_sel = 0; in_srcs = '0; in_srcs[31:0] = 32'hB0B0_0001;
        in_rd = 6; in_reg_write = 1; wb_ready = 0;
        @(negedge clk);
        in_srcs[31:0] = 32'h1111_2222; in_rd = 17;
        for (int i = 0; i < 5; i++) begin
            #1 chk("bp_valid", wb_valid, 1);
            chk("bp_data", wb_data, 32'hB0B0_0001);
            chk("bp_rd", wb_rd, 6);
            chk("bp_we", wb_we, 1);
            chk("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        in_valid = 0; wb_ready = 1;
        @(negedge clk);
        chk("bp_release_valid", wb_valid, 0);
        chk("bp_release_in_ready", in_ready, 1);

        // stray load data while idle is ignored
        mem_rvalid = 1; mem_rdata = 32'h7777_7777;
        repeat (2) begin
            @(negedge clk);
            chk("idle_rvalid_valid", wb_valid, 0);
            chk("idle_rvalid_data", wb_data, 32'hB0B0_0001);
        end
        mem_rvalid = 0;

        // reset while waiting for load data
        @(negedge clk);
        in_valid = 1; in_src_sel = 1; in_funct3 = 2; in_rd = 4; in_reg_write = 1;
        @(negedge clk);
        in_valid = 0;
        chk("rl_wait_ready", in_ready, 0);
        reset = 1;
        #1 chk("rl_rst_in_ready", in_ready, 1);
        chk("rl_rst_valid", wb_valid, 0);
        chk("rl_rst_data", wb_data, 0);
        @(negedge clk);
        reset = 0; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_rvalid = 0;
        chk("rl_late_rvalid", wb_valid, 0);
        chk("rl_late_ready", in_ready, 1);
        @(negedge clk);
        chk("rl_late_rvalid2", wb_valid, 0);

        // randomized traffic against a one-slot transaction model
        out_full = 0; load_wait = 0; cur_we = 0; cur_rd = 0; cur_data = 0;
        pend_we = 0; pend_rd = 0; pend_f3 = 0; pend_off = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            in_valid = $urandom_range(0, 2) != 0;
            in_src_sel = 3'($urandom);
            in_srcs = {$urandom, $urandom, $urandom, $urandom, $urandom};
            in_funct3 = 3'($urandom); in_byte_off = 2'($urandom);
            in_rd = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom);
            in_reg_write = 1'($urandom);
            mem_rvalid = $urandom_range(0, 2) == 0; mem_rdata = $urandom;
            wb_ready = $urandom_range(0, 3) != 0;
            #1;
            exp_ready = !load_wait && (!out_full || wb_ready);
            chk("rnd_in_ready", in_ready, exp_ready);
            chk("rnd_wb_valid", wb_valid, out_full);
            if (out_full) begin
                chk("rnd_wb_data", wb_data, cur_data);
                chk("rnd_wb_rd", wb_rd, cur_rd);
                chk("rnd_wb_we", wb_we, cur_we);
            end
            if (load_wait) begin
                if (mem_rvalid) begin
                    cur_data = 32'(ref_ext(64'(mem_rdata), pend_f3, pend_off, 32));
                    cur_rd = pend_rd; cur_we = pend_we;
                    out_full = 1; load_wait = 0;
                end
            end else if (in_valid && exp_ready) begin
                if (in_src_sel == 1) begin
                    pend_rd = in_rd; pend_we = in_reg_write && in_rd != 0;
                    pend_f3 = in_funct3; pend_off = in_byte_off;
                    load_wait = 1; out_full = 0;
                end else begin
                    cur_rd = in_rd; cur_we = in_reg_write && in_rd != 0;
                    cur_data = in_src_sel < NS ? in_srcs[in_src_sel*XL +: XL] : 32'd0;
                    out_full = 1;
                end
            end else if (out_full && wb_ready) out_full = 0;
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/wb_result_unit.md
# wb_result_unit

Registered, parametrised write-back result selector for the pipelined core. It picks one of `NSRC` packed result sources (ALU, load data, PC+4, further sources). Load data arrives from the data memory an arbitrary number of cycles after the instruction is accepted; the block waits for it, then aligns and sign- or zero-extends it. The finished write-back is presented to the register file through a valid/ready handshake. The block sits between the execute/memory stage and the register file write port.

## Interface
Parameters:
- `XLEN`, default 32: datapath width; legal values are 32 and 64.
- `NSRC`, default 4: number of source slots, at least 3. Slot 0 is ALU, slot 1 is load, slot 2 is PC+4, and slots 3 and above are generic.
- `SELW`, default `$clog2(NSRC)`: select width.

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  an instruction result is offered.
- `in_ready`  out  1  the block accepts the offer this cycle.
- `in_src_sel`  in  `SELW`  source index.
- `in_srcs`  in  `NSRC*XLEN`  packed sources; slot k is at `[k*XLEN +: XLEN]`. Slot 1 content is ignored.
- `in_funct3`  in  3  load size/sign code.
- `in_byte_off`  in  2  low address bits of the load.
- `in_rd`  in  5  destination register.
- `in_reg_write`  in  1  the instruction writes `rd`.
- `mem_rvalid`  in  1  load data valid.
- `mem_rdata`  in  `XLEN`  raw load word.
- `wb_valid`  out  1  write-back pending.
- `wb_ready`  in  1  register file takes it.
- `wb_we`  out  1  register write enable.
- `wb_rd`  out  5  write address.
- `wb_data`  out  `XLEN`  write data.

## Operation
- FSM states are IDLE, WAIT_MEM and OUT.
- `in_ready` = (state==IDLE) | (state==OUT & `wb_ready`). It is combinational from state and `wb_ready`.
- Accept = `in_valid` & `in_ready`. On accept, `in_rd` is captured and `wb_we` is set to `in_reg_write` & (`in_rd`!=0).
- Non-load accept (`in_src_sel`!=1):
  - `wb_data` gets slot `in_src_sel`. An out-of-range index (≥`NSRC`) gives 0.
  - Next state is OUT.
- Load accept (`in_src_sel`==1):
  - `in_funct3` and `in_byte_off` are captured. Next state is WAIT_MEM.
- WAIT_MEM:
  - On `mem_rvalid`, `wb_data` gets the extended load value and the state moves to OUT.
  - Otherwise the state holds indefinitely; there is no timeout.
- Load extraction: let s = `mem_rdata` >> (8*byte_off).
  - `000` sign-extends s[7:0].
  - `001` sign-extends s[15:0].
  - `010` sign-extends s[31:0] to `XLEN`.
  - `100` zero-extends s[7:0].
  - `101` zero-extends s[15:0].
  - `110` zero-extends s[31:0].
  - Any other code passes `mem_rdata` unchanged.
  - Misalignment is not checked: bits shifted out are lost, and vacated bits are 0.
- OUT:
  - `wb_valid`=1, and `wb_we`, `wb_rd` and `wb_data` are held stable until `wb_ready`.
  - On `wb_ready` without a new accept, the state goes to IDLE and `wb_valid`=0.
  - On `wb_ready` with a new accept in the same cycle, the new result replaces the old one. The next state is OUT (non-load) or WAIT_MEM (load).
- `mem_rvalid` outside WAIT_MEM, including in the accept cycle itself, is ignored.

## Timing
- Reset values:
  - state IDLE; `wb_valid`=0, `wb_we`=0, `wb_rd`=0, `wb_data`=0.
  - `in_ready` reads 1 during and after reset.
- Reset asserted mid-operation (WAIT_MEM or OUT) immediately drops the pending result. A `mem_rvalid` that arrives after reset is released is ignored.
- Non-load latency: accept at edge N, so `wb_valid`=1 after edge N.
- Sustained throughput is 1 result per cycle when `wb_ready` is held at 1.
- Load latency: 1 cycle after the `mem_rvalid` edge. Earliest `wb_valid` is 2 edges after accept.
- During WAIT_MEM `in_ready`=0 and `wb_valid`=0, so the upstream stalls.
- With `wb_ready`=0 in OUT, `in_ready`=0. This backpressure propagates combinationally.
- No combinational path from `in_*` or `mem_*` to any `wb_*` output; every `wb_*` output is registered.

## Test plan
- Reset and ALU pass: release reset. Check `wb_valid`=0 and `in_ready`=1. Offer sel=0, slot0=0x0000_1234, rd=5, we=1 with `wb_ready`=1. Next cycle: `wb_valid`=1, `wb_data`=0x0000_1234, `wb_rd`=5, `wb_we`=1.
- Back-to-back streaming: send 4 consecutive accepts (sel 0, 2, 3, 0) with `wb_ready`=1. Expect 4 consecutive `wb_valid` cycles in order, with no bubbles.
- Load extend: offer sel=1, funct3=000, off=2. Wait 3 cycles, then `mem_rvalid` with rdata=0x0080_0000. Expect `wb_data`=0xFFFF_FF80 one cycle later. Repeat with funct3=100: expect 0x0000_0080. Repeat with funct3=101, off=2, rdata=0x8001_0000: expect 0x0000_8001.
- Backpressure and hazards:
  - Hold `wb_ready`=0 for 5 cycles in OUT: outputs stay stable and `in_ready`=0.
  - `mem_rvalid` pulsed while IDLE: no output change.
  - rd=0 with we=1: `wb_we`=0.
- Reset mid-load and out-of-range: assert reset in WAIT_MEM, release, then pulse `mem_rvalid`: `wb_valid` stays 0. With `NSRC`=5, sel=7: `wb_data`=0.
- Parameter check: with `XLEN`=64, `NSRC`=3, funct3=010, rdata=0x0000_0000_8000_0000. Expect 0xFFFF_FFFF_8000_0000.
